// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - registered instruction decoder with 2-entry skid buffer and wrong-path squash
module decode_stage_pipe #(
  parameter int INSTR_W  = 16,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int BR_OFF_W = 7,
  parameter int SQUASH_N = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iValid,
  output logic                oReady,
  input  logic [INSTR_W-1:0]  wInstruction,
  input  logic                wZa,
  input  logic                wZb,
  input  logic                wCa,
  input  logic                wCb,
  input  logic                wNa,
  input  logic                wNb,
  input  logic                iFlush,
  output logic                oValid,
  input  logic                iReady,
  output logic                rBranch_taken,
  output logic                rJumpTaken,
  output logic                rMux_a_sel,
  output logic                rMux_b_sel,
  output logic [ADDR_W-1:0]   rBranch_dir,
  output logic [DATA_W-1:0]   rC
);

  // One decoded instruction as held in the output or skid register
  typedef struct packed {
    logic              br;
    logic              jmp;
    logic              mux_a;
    logic              mux_b;
    logic [ADDR_W-1:0] dir;
    logic [DATA_W-1:0] imm;
  } entry_t;

  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_N);

  // Pure decode of an instruction plus the flags present at acceptance
  function automatic entry_t decode(input logic [INSTR_W-1:0] ins,
                                    input logic za, input logic zb,
                                    input logic ca, input logic cb,
                                    input logic na, input logic nb);
    entry_t     e;
    logic [5:0] op;
    logic       take;
    e    = '0;
    op   = ins[INSTR_W-1 -: 6];
    take = 1'b0;
    case (op)
      6'h0F, 6'h12, 6'h14, 6'h16, 6'h18: begin
        e.mux_a = 1'b1;
        e.imm   = ins[DATA_W-1:0];
      end
      6'h10, 6'h11, 6'h13, 6'h15, 6'h17: begin
        e.mux_b = 1'b1;
        e.imm   = ins[DATA_W-1:0];
      end
      6'h19: begin
        e.jmp = 1'b1;
        e.dir = ins[ADDR_W-1:0];
      end
      6'h1A: take = za;
      6'h1B: take = !za;
      6'h1C: take = ca;
      6'h1D: take = !ca;
      6'h1E: take = na;
      6'h1F: take = !na;
      6'h20: take = zb;
      6'h21: take = !zb;
      6'h22: take = cb;
      6'h23: take = !cb;
      6'h24: take = nb;
      6'h25: take = !nb;
      default: take = 1'b0;
    endcase
    if (take) begin
      e.br  = 1'b1;
      e.dir = {{(ADDR_W-BR_OFF_W){1'b0}}, ins[BR_OFF_W-1:0]};
    end
    return e;
  endfunction

  entry_t     out_q;
  entry_t     skid_q;
  entry_t     dec;
  logic       out_valid;
  logic       skid_valid;
  logic [2:0] squash_cnt;
  logic       accept;
  logic       transfer;
  logic       taken_xfer;
  logic       drop;
  logic       keep;

  assign dec        = decode(wInstruction, wZa, wZb, wCa, wCb, wNa, wNb);
  assign accept     = iValid & oReady;
  assign transfer   = out_valid & iReady;
  assign taken_xfer = transfer & (out_q.br | out_q.jmp);
  // Inputs accepted on a flush, on the edge a taken transfer leaves, or while
  // the squash counter runs are handshaken but never enter the pipeline.
  assign drop       = iFlush | (taken_xfer & (SQUASH_N != 0)) | (squash_cnt != 3'd0);
  assign keep       = accept & !drop;

  // Ready is simply "skid register is free", so it only falls a cycle after the skid fills
  assign oReady        = !skid_valid;
  assign oValid        = out_valid;
  assign rBranch_taken = out_q.br;
  assign rJumpTaken    = out_q.jmp;
  assign rMux_a_sel    = out_q.mux_a;
  assign rMux_b_sel    = out_q.mux_b;
  assign rBranch_dir   = out_q.dir;
  assign rC            = out_q.imm;

  // Output and skid registers: load, drain, squash-discard and flush
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (iFlush) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (transfer) begin
      // Whatever sits in skid either moves up or, behind a taken transfer, is wrong-path
      skid_valid <= 1'b0;
      if (skid_valid && !taken_xfer) begin
        out_q <= skid_q;
      end else if (keep) begin
        out_q <= dec;
      end else begin
        out_valid <= 1'b0;
        out_q     <= '0;
      end
    end else if (keep) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_q     <= dec;
      end else begin
        skid_valid <= 1'b1;
        skid_q     <= dec;
      end
    end
  end

  // Squash counter: armed by a taken transfer leaving the stage, counts down on dropped inputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      squash_cnt <= 3'd0;
    end else if (iFlush) begin
      squash_cnt <= 3'd0;
    end else if (taken_xfer) begin
      if (SQUASH_N == 0) squash_cnt <= 3'd0;
      else               squash_cnt <= SQ_LOAD - {2'b00, accept};
    end else if (accept && squash_cnt != 3'd0) begin
      squash_cnt <= squash_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed and randomized checks of decode_stage_pipe against a queue model
module tb_decode_stage_pipe;

  localparam int SQ = 1;

  logic        Clock;
  logic        Reset;
  logic        iValid;
  logic        oReady;
  logic [15:0] wInstruction;
  logic        wZa, wZb, wCa, wCb, wNa, wNb;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  logic        rBranch_taken, rJumpTaken, rMux_a_sel, rMux_b_sel;
  logic [9:0]  rBranch_dir;
  logic [7:0]  rC;

  decode_stage_pipe #(
    .INSTR_W(16), .DATA_W(8), .ADDR_W(10), .BR_OFF_W(7), .SQUASH_N(SQ)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .wInstruction(wInstruction),
    .wZa(wZa), .wZb(wZb), .wCa(wCa), .wCb(wCb), .wNa(wNa), .wNb(wNb),
    .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .rBranch_taken(rBranch_taken), .rJumpTaken(rJumpTaken),
    .rMux_a_sel(rMux_a_sel), .rMux_b_sel(rMux_b_sel),
    .rBranch_dir(rBranch_dir), .rC(rC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit br;
    bit jmp;
    bit ma;
    bit mb;
    int dir;
    int c;
  } ent_t;

  ent_t q[$];
  int   cnt;
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [9:0] lo);
    return {op, lo};
  endfunction

  // Decode straight from the opcode table, using opcode arithmetic for the families
  function automatic ent_t ref_dec(input logic [15:0] ins,
                                   input bit za, input bit zb, input bit ca,
                                   input bit cb, input bit na, input bit nb);
    ent_t e;
    int   op;
    int   idx;
    int   k;
    bit   f;
    bit   fl[3];
    e  = '{default: 0};
    op = int'(ins[15:10]);
    if (op >= 15 && op <= 24) begin
      e.c = int'(ins[7:0]);
      if (op == 15)                 e.ma = 1;
      else if (op == 16)            e.mb = 1;
      else if ((op - 17) % 2 == 0)  e.mb = 1;
      else                          e.ma = 1;
    end else if (op == 25) begin
      e.jmp = 1;
      e.dir = int'(ins[9:0]);
    end else if (op >= 26 && op <= 37) begin
      idx = op - 26;
      if (idx < 6) begin fl[0] = za; fl[1] = ca; fl[2] = na; end
      else         begin fl[0] = zb; fl[1] = cb; fl[2] = nb; end
      k = idx % 6;
      f = fl[k / 2];
      if (f == ((k % 2) == 0)) begin
        e.br  = 1;
        e.dir = int'(ins[6:0]);
      end
    end
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_advance();
    bit   acc;
    bit   xfer;
    bit   tk;
    bit   drop;
    ent_t e;
    acc  = iValid && (q.size() < 2);
    xfer = (q.size() > 0) && iReady;
    e    = ref_dec(wInstruction, wZa, wZb, wCa, wCb, wNa, wNb);
    drop = 0;
    if (Reset || iFlush) begin
      q.delete();
      cnt = 0;
      return;
    end
    if (xfer) begin
      tk = q[0].br || q[0].jmp;
      void'(q.pop_front());
      if (tk) begin
        q.delete();
        if (SQ > 0) begin
          cnt  = SQ - (acc ? 1 : 0);
          drop = acc;
        end
      end else if (acc && cnt > 0) begin
        drop = 1;
        cnt--;
      end
    end else if (acc && cnt > 0) begin
      drop = 1;
      cnt--;
    end
    if (acc && !drop) q.push_back(e);
  endtask

  task automatic compare_all();
    check("ready", oReady, (q.size() < 2) ? 1 : 0);
    check("valid", oValid, (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) begin
      check("br",   rBranch_taken, q[0].br);
      check("jmp",  rJumpTaken,    q[0].jmp);
      check("mux_a", rMux_a_sel,   q[0].ma);
      check("mux_b", rMux_b_sel,   q[0].mb);
      check("dir",  rBranch_dir,   q[0].dir);
      check("imm",  rC,            q[0].c);
    end
  endtask

  task automatic step();
    model_advance();
    @(posedge Clock);
    @(negedge Clock);
    compare_all();
  endtask

  task automatic offer(input bit v, input logic [15:0] ins);
    iValid       = v;
    wInstruction = ins;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, oValid, 0);
    check({tag, "_ready"}, oReady, 1);
    check({tag, "_ctl"}, {rBranch_taken, rJumpTaken, rMux_a_sel, rMux_b_sel}, 0);
    check({tag, "_dir"}, rBranch_dir, 0);
    check({tag, "_imm"}, rC, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cnt      = 0;
    Reset    = 1'b1;
    iValid   = 1'b0;
    iReady   = 1'b1;
    iFlush   = 1'b0;
    wInstruction = '0;
    {wZa, wZb, wCa, wCb, wNa, wNb} = '0;
    @(negedge Clock);
    @(negedge Clock);
    check_zero_outputs("rst");
    Reset = 1'b0;

    // Constant loads streaming back to back
    offer(1, mk(6'h0F, 10'h05A)); step();
    check("s1_mux_a", rMux_a_sel, 1); check("s1_imm", rC, 8'h5A);
    offer(1, mk(6'h12, 10'h033)); step();
    check("s2_mux_a", rMux_a_sel, 1); check("s2_imm", rC, 8'h33);
    offer(1, mk(6'h01, 10'h000)); step();
    check("s3_valid", oValid, 1);
    check("s3_ctl", {rBranch_taken, rJumpTaken, rMux_a_sel, rMux_b_sel, rC}, 0);
    offer(0, '0); step();

    // BAEQ taken then not taken; the filler after the taken one is squashed
    wZa = 1'b1;
    offer(1, mk(6'h1A, 10'h045)); step();
    check("beq_t_br", rBranch_taken, 1); check("beq_t_dir", rBranch_dir, 10'h045);
    wZa = 1'b0;
    offer(1, mk(6'h00, 10'h000)); step();
    check("beq_sq_valid", oValid, 0);
    offer(1, mk(6'h1A, 10'h045)); step();
    check("beq_n_valid", oValid, 1);
    check("beq_n_br", rBranch_taken, 0); check("beq_n_dir", rBranch_dir, 0);
    offer(0, '0); step();

    // Backpressure: two accepted, third refused until drained
    iReady = 1'b0;
    offer(1, mk(6'h0F, 10'h0A1)); step();
    check("bp1_imm", rC, 8'hA1); check("bp1_ready", oReady, 1);
    offer(1, mk(6'h0F, 10'h0A2)); step();
    check("bp2_imm", rC, 8'hA1); check("bp2_ready", oReady, 0);
    wZa = 1'b1;
    offer(1, mk(6'h0F, 10'h0A3)); step();
    check("bp3_ready", oReady, 0); check("bp3_imm", rC, 8'hA1);
    wZa = 1'b0;
    offer(0, '0); iReady = 1'b1; step();
    check("bp4_imm", rC, 8'hA2);
    step();
    check("bp5_valid", oValid, 0);

    // Jump squashes exactly one following instruction
    offer(1, mk(6'h19, 10'h2AB)); step();
    check("jmp_taken", rJumpTaken, 1); check("jmp_dir", rBranch_dir, 10'h2AB);
    offer(1, mk(6'h0F, 10'h011)); step();
    check("jmp_sq_valid", oValid, 0);
    offer(1, mk(6'h10, 10'h022)); step();
    check("jmp_next_mux_b", rMux_b_sel, 1); check("jmp_next_imm", rC, 8'h22);
    offer(0, '0); step();

    // Flush with both entries full and a taken jump transferring on the same edge
    iReady = 1'b0;
    offer(1, mk(6'h19, 10'h155)); step();
    offer(1, mk(6'h0F, 10'h077)); step();
    iReady = 1'b1; iFlush = 1'b1;
    offer(1, mk(6'h0F, 10'h099)); step();
    check("fl_valid", oValid, 0); check("fl_ready", oReady, 1);
    iFlush = 1'b0;
    offer(1, mk(6'h0F, 10'h03C)); step();
    check("fl_next_valid", oValid, 1); check("fl_next_imm", rC, 8'h3C);
    offer(0, '0); step();

    // Asynchronous reset between edges
    offer(1, mk(6'h0F, 10'h055)); step();
    offer(0, '0);
    #2;
    Reset = 1'b1;
    q.delete();
    cnt = 0;
    #1;
    check_zero_outputs("arst");
    @(negedge Clock);
    Reset = 1'b0;
    offer(1, mk(6'h0F, 10'h066)); step();
    check("arst_resume_imm", rC, 8'h66);
    offer(0, '0); step();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      iValid       = ($urandom_range(0, 3) != 0);
      iReady       = ($urandom_range(0, 3) != 0);
      iFlush       = ($urandom_range(0, 39) == 0);
      wInstruction = {6'($urandom_range(0, 39)), 10'($urandom)};
      {wZa, wZb, wCa, wCb, wNa, wNb} = 6'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised, registered successor to the combinational instruction decoder. It accepts one instruction per cycle from fetch over a valid/ready handshake and decodes opcode, immediate and branch/jump control. Flags are sampled at acceptance. Results are held in a 2-entry skid pipeline toward the execute stage. After a taken jump or branch it squashes the wrong-path instructions, and it supports an external flush.

## Interface
- INSTR_W, 16: instruction width; opcode = wInstruction[INSTR_W-1 -: 6]
- DATA_W, 8: immediate width; rC = wInstruction[DATA_W-1:0]
- ADDR_W, 10: jump/branch target width
- BR_OFF_W, 7: branch target field wInstruction[BR_OFF_W-1:0], zero-extended to ADDR_W
- SQUASH_N, 1: wrong-path instructions dropped after a taken transfer (0..7)
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- iValid  in  1  fetch offers wInstruction
- oReady  out  1  stage can accept
- wInstruction  in  INSTR_W  instruction
- wZa, wZb, wCa, wCb, wNa, wNb  in  1 each  flags, sampled when the instruction is accepted
- iFlush  in  1  discard everything in flight
- oValid  out  1  decoded entry present
- iReady  in  1  execute consumes the entry
- rBranch_taken, rJumpTaken, rMux_a_sel, rMux_b_sel  out  1 each  decoded control
- rBranch_dir  out  ADDR_W  target; 0 unless rBranch_taken or rJumpTaken
- rC  out  DATA_W  immediate; 0 for non-constant opcodes

## Operation
- Opcodes (hex): 00 NOP; 01–0E register ops, all controls 0.
- LDCA=0F: mux_a=1.
- LDCB=10: mux_b=1.
- ADDCA/SUBCA/ANDCA/ORCA = 11/13/15/17: mux_b=1.
- ADDCB/SUBCB/ANDCB/ORCB = 12/14/16/18: mux_a=1.
- Every constant op (0F–18) loads rC.
- JMP=19: rJumpTaken=1, rBranch_dir=wInstruction[ADDR_W-1:0].
- Branches 1A–25, in order BAEQ, BANE, BACS, BACC, BAMI, BAPL, BBEQ, BBNE, BBCS, BBCC, BBMI, BBPL.
- Branch conditions: Za=1, Za=0, Ca=1, Ca=0, Na=1, Na=0, then the same six conditions on the B flags.
- A taken branch sets rBranch_taken=1 and rBranch_dir to the zero-extended offset field.
- A not-taken branch sets rBranch_dir=0. Unlisted opcodes decode as NOP.
- Accept: iValid & oReady at an edge. The decoded entry goes into the output register if it is empty or being consumed; otherwise it goes into the skid register.
- oReady = !skid_valid, registered. Skid drains to the output register when the output is consumed.
- Transfer: oValid & iReady.
- Squash:
  - When a transferred entry has rBranch_taken|rJumpTaken, the skid entry is discarded at that edge.
  - The squash counter loads SQUASH_N, minus 1 if an input is accepted at that same edge; that input is dropped.
  - While the counter is nonzero, each accepted input is dropped and the counter decrements.
  - Dropped inputs are still handshaken (oReady unaffected).
- iFlush at an edge:
  - clears the output register, skid register and squash counter;
  - drops an input accepted that edge;
  - takes precedence over squash and transfer.

## Timing
- Reset values: oValid=0, all decoded outputs 0, skid empty, squash counter 0, oReady=1.
- Latency 1: input accepted at edge k is on the outputs, oValid=1, after edge k.
- Throughput 1/cycle while iReady=1. With iReady=0, two entries are accepted, then oReady=0 from the following cycle.
- Outputs change only on transfer/load edges. They are stable while oValid & !iReady.
- Flags are captured at acceptance, so later flag changes do not alter a held entry.
- Reset asserted mid-operation clears state immediately and asynchronously. Nothing in flight survives.
- Taken transfer and iFlush at the same edge: flush wins, counter=0.
- SQUASH_N=0: skid discard only, no further drops.
- Non-taken branches never trigger squash.

## Test plan
- Reset, then stream 0F_5A, 12_33, 01_00 with iReady=1.
  - Required: one cycle after each accept, rMux_a_sel=1/rC=5A, then rMux_a_sel=1/rC=33, then all 0.
- BAEQ with offset 0x45: once with Za=1, once with Za=0.
  - Required: rBranch_taken=1, rBranch_dir=0x045; then 0 and 0x000.
- iReady=0, offer three instructions.
  - Required: two accepted, oReady=0 from the following cycle.
  - Then iReady=1: entries emerge in order with no loss.
- JMP 0x2AB followed back-to-back by 0F_11, 10_22 (SQUASH_N=1).
  - Required: rJumpTaken=1, rBranch_dir=0x2AB.
  - The one instruction after JMP is dropped; 10_22 is delivered.
- iFlush with both entries full and squash active.
  - Required next cycle: oValid=0, oReady=1, next input delivered.
- Assert Reset asynchronously mid-stream.
  - Required: outputs 0 before the next edge, stream resumes cleanly after release.
